// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit ripple slice reused over WIDTH/4 cycles,
// least-significant nibble first, with the inter-nibble carry held in a register.
module nibble_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c_msb,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign c_msb = c[3];
  assign co    = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, work;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [3:0]       s4;
  logic             c_msb, c_out, last;
  logic [WIDTH-1:0] work_nx;

  // Operands shift right each RUN cycle so the slice always sees the current nibble at [3:0];
  // the working register fills from the top, so after NIB shifts it holds the full result.
  nibble_slice u_slice (
    .x     (a_q[3:0]),
    .y     (b_q[3:0]),
    .ci    (carry),
    .s     (s4),
    .c_msb (c_msb),
    .co    (c_out)
  );

  assign work_nx = {s4, work[WIDTH-1:4]};
  assign last    = (idx == IDX_W'(NIB - 1));
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      work  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= sub | cin;
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          carry <= c_out;
          work  <= work_nx;
          idx   <= idx + 1'b1;
          if (last) begin
            // Signed overflow: carry into the MSB disagrees with carry out of it.
            sum   <= work_nx;
            cout  <= c_out;
            ovf   <= c_msb ^ c_out;
            idx   <= '0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
